spr_dma: RTL and testbench

SPR_DMA -- requirements
Module: spr_dma

---
 rtl/spr_dma.sv | 88 ++++++++
 tb/tb_spr_dma.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spr_dma.sv
// Sprite DMA engine: on a CPU write of TRIG_ADDR it copies 256 bytes from
// page {din,8'h00} to the PPU OAM data port, taking 2 cycles per byte.
// Ports:
//   clk_in, nrst_in          - clock, async active-low reset
//   cpumc_a_in/din_in/r_nw_in - snooped CPU bus (trigger detect)
//   cpumc_dout_in            - memory read data, one cycle after address
//   active_out               - DMA owns the bus (CPU held while high)
//   cpumc_a_out/d_out/r_nw_out - DMA-driven bus
module spr_dma #(
   parameter logic [15:0] TRIG_ADDR     = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
   input  logic        clk_in,
   input  logic        nrst_in,
   input  logic [15:0] cpumc_a_in,
   input  logic [7:0]  cpumc_din_in,
   input  logic        cpumc_r_nw_in,
   input  logic [7:0]  cpumc_dout_in,
   output logic        active_out,
   output logic [15:0] cpumc_a_out,
   output logic [7:0]  cpumc_d_out,
   output logic        cpumc_r_nw_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      READ  = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] cnt_q, cnt_d;
   logic       active_q, active_d;

   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         state_q  <= IDLE;
         page_q   <= 8'h00;
         cnt_q    <= 8'h00;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      page_d         = page_q;
      cnt_d          = cnt_q;
      cpumc_a_out    = 16'h0000;
      cpumc_d_out    = 8'h00;
      cpumc_r_nw_out = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (!cpumc_r_nw_in && (cpumc_a_in == TRIG_ADDR)) begin
               state_d = START;
               page_d  = cpumc_din_in;
               cnt_d   = 8'h00;
            end
         end
         // One bus-idle cycle lets the CPU halt settle before we drive.
         START: state_d = READ;
         READ: begin
            cpumc_a_out = {page_q, cnt_q};
            state_d     = WRITE;
         end
         WRITE: begin
            cpumc_a_out    = OAM_DATA_ADDR;
            cpumc_r_nw_out = 1'b0;
            // Read data arrives the cycle after the READ address.
            cpumc_d_out    = cpumc_dout_in;
            cnt_d          = cnt_q + 8'd1;
            state_d        = (cnt_q == 8'hFF) ? IDLE : READ;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered so the CPU hold has no path from the snooped bus.
   assign active_d   = (state_d != IDLE);
   assign active_out = active_q;

endmodule

// File: tb/tb_spr_dma.sv
// Directed testbench for spr_dma: full transfers, wrap, ignored retrigger,
// mid-transfer reset, non-trigger accesses and back-to-back transfers.
module tb_spr_dma;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [15:0] a_in = 16'h0000;
   logic [7:0]  din = 8'h00;
   logic        rnw_in = 1'b1;
   logic [7:0]  dout = 8'h00;
   logic        active;
   logic [15:0] a_out;
   logic [7:0]  d_out;
   logic        rnw_out;

   int total = 0;
   int bad = 0;
   int run = 0;
   int gap = 0;
   int last_run = 0;
   int last_gap = 0;
   int wr_cnt = 0;
   logic prev = 1'b0;

   spr_dma dut (
      .clk_in        (clk),
      .nrst_in       (nrst),
      .cpumc_a_in    (a_in),
      .cpumc_din_in  (din),
      .cpumc_r_nw_in (rnw_in),
      .cpumc_dout_in (dout),
      .active_out    (active),
      .cpumc_a_out   (a_out),
      .cpumc_d_out   (d_out),
      .cpumc_r_nw_out(rnw_out)
   );

   always #10 clk = ~clk;

   function automatic logic [7:0] memf(input logic [15:0] a);
      logic [7:0] lo;
      lo = a[7:0] * 8'd3;
      return lo ^ a[15:8] ^ 8'hA5;
   endfunction

   // Memory model: data valid one cycle after the address.
   always @(posedge clk) dout <= memf(a_out);

   // Active run length, idle gap and OAM write counters.
   always @(posedge clk) begin
      if (active) begin
         run <= run + 1;
         if (!prev) last_gap <= gap;
         gap <= 0;
      end else begin
         if (prev) last_run <= run;
         run <= 0;
         gap <= gap + 1;
      end
      prev <= active;
      if (!rnw_out && a_out == 16'h2004) wr_cnt <= wr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge with the DUT idle; returns at a negedge in IDLE.
   task automatic xfer(input logic [7:0] pg, input int inj, input int abort);
      int w0;
      logic [7:0] b;
      a_in = 16'h4014;
      rnw_in = 1'b0;
      din = pg;
      @(negedge clk);
      a_in = 16'h0000;
      rnw_in = 1'b1;
      din = 8'h00;
      chk("start_act", {31'd0, active}, 32'd1);
      chk("start_a", {16'd0, a_out}, 32'h0);
      chk("start_rnw", {31'd0, rnw_out}, 32'd1);
      w0 = wr_cnt;
      for (int i = 0; i < 256; i++) begin
         b = i[7:0];
         @(negedge clk);
         chk("rd_act", {31'd0, active}, 32'd1);
         chk("rd_a", {16'd0, a_out}, {16'd0, pg, b});
         chk("rd_rnw", {31'd0, rnw_out}, 32'd1);
         if (i == inj) begin
            a_in = 16'h4014;
            rnw_in = 1'b0;
            din = 8'h05;
         end
         if (i == abort) begin
            w0 = wr_cnt;
            nrst = 1'b0;
            #1;
            chk("rst_act", {31'd0, active}, 32'd0);
            chk("rst_a", {16'd0, a_out}, 32'h0);
            chk("rst_d", {24'd0, d_out}, 32'h0);
            chk("rst_rnw", {31'd0, rnw_out}, 32'd1);
            @(negedge clk);
            @(negedge clk);
            nrst = 1'b1;
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               chk("post_rst_act", {31'd0, active}, 32'd0);
            end
            chk("post_rst_wr", wr_cnt - w0, 32'd0);
            return;
         end
         @(negedge clk);
         if (i == inj) begin
            a_in = 16'h0000;
            rnw_in = 1'b1;
            din = 8'h00;
         end
         chk("wr_act", {31'd0, active}, 32'd1);
         chk("wr_a", {16'd0, a_out}, 32'h2004);
         chk("wr_rnw", {31'd0, rnw_out}, 32'd0);
         chk("wr_d", {24'd0, d_out}, {24'd0, memf({pg, b})});
      end
      @(negedge clk);
      chk("end_act", {31'd0, active}, 32'd0);
      chk("end_a", {16'd0, a_out}, 32'h0);
      chk("end_rnw", {31'd0, rnw_out}, 32'd1);
      chk("end_d", {24'd0, d_out}, 32'h0);
      chk("wr_total", wr_cnt - w0, 32'd256);
   endtask

   initial begin
      #5;
      chk("reset_act", {31'd0, active}, 32'd0);
      chk("reset_a", {16'd0, a_out}, 32'h0);
      chk("reset_d", {24'd0, d_out}, 32'h0);
      chk("reset_rnw", {31'd0, rnw_out}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // CPU read of the trigger address, then write to a neighbour.
      a_in = 16'h4014;
      rnw_in = 1'b1;
      din = 8'h02;
      @(negedge clk);
      a_in = 16'h4015;
      rnw_in = 1'b0;
      @(negedge clk);
      a_in = 16'h0000;
      rnw_in = 1'b1;
      din = 8'h00;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("no_trig_act", {31'd0, active}, 32'd0);
      end

      // Back-to-back: page 02 then page FF with a one-cycle idle gap.
      xfer(8'h02, -1, -1);
      xfer(8'hFF, -1, -1);
      @(negedge clk);
      chk("b2b_len", last_run, 32'd513);
      chk("b2b_gap", last_gap, 32'd1);

      // Retrigger with page 05 mid-transfer must be ignored.
      xfer(8'h02, 10, -1);
      @(negedge clk);
      chk("retrig_len", last_run, 32'd513);

      // Reset pulse at byte 100.
      xfer(8'h37, -1, 100);

      // Recovery with page 00.
      xfer(8'h00, -1, -1);
      @(negedge clk);
      chk("pg0_len", last_run, 32'd513);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
